upb_tcam_entry_writer: RTL and testbench

//  Programming sequencer for one SRL-based TCAM entry (upb_tcam_entry).
//  - Accepts a (value, mask) rule over TCAM_WIDTH fields of log2(SRL_SIZE) bits each.
//  - Emits the wdata/waddr/wen shift sequence that loads every SRL with its per-address match truth table.
//  - Sits between the flow-table management logic and the TCAM entry.
//  - Drives entry_valid so downstream lookup logic ignores the entry's match output while the SRLs are being rewritten.

---
 rtl/upb_tcam_entry_writer_if.sv | 51 +++++
 rtl/upb_tcam_entry_writer.sv | 178 +++++++++++++++++
 tb/tb_upb_tcam_entry_writer.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/upb_tcam_entry_writer_if.sv
`default_nettype none
// ============================================================================
// Module   : upb_tcam_entry_writer_if
// Brief    : Command and TCAM-programming bus between requester, writer and entry.
//            cmd_inv exists only when UPB_TCAM_WRITER_INVALIDATE_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
interface upb_tcam_entry_writer_if #(
    parameter int SRL_SIZE    = 32,
    parameter int TCAM_WIDTH  = 49,
    parameter int INPUT_WIDTH = 32
);
    localparam int c_AW  = $clog2(SRL_SIZE);
    localparam int c_KW  = c_AW * TCAM_WIDTH;
    localparam int c_NCH = (TCAM_WIDTH + INPUT_WIDTH - 1) / INPUT_WIDTH;
    localparam int c_CW  = (c_NCH > 1) ? $clog2(c_NCH) : 1;

    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [c_KW-1:0]        cmd_value;
    logic [c_KW-1:0]        cmd_mask;
`ifdef UPB_TCAM_WRITER_INVALIDATE_EN
    logic                   cmd_inv;
`endif
    logic [INPUT_WIDTH-1:0] tcam_wdata;
    logic [c_CW-1:0]        tcam_waddr;
    logic                   tcam_wen;
    logic                   entry_valid;
    logic                   done;

`ifdef UPB_TCAM_WRITER_INVALIDATE_EN
    modport master (
        output cmd_valid, cmd_value, cmd_mask, cmd_inv,
        input  cmd_ready, tcam_wdata, tcam_waddr, tcam_wen, entry_valid, done
    );
    modport slave (
        input  cmd_valid, cmd_value, cmd_mask, cmd_inv,
        output cmd_ready, tcam_wdata, tcam_waddr, tcam_wen, entry_valid, done
    );
`else
    modport master (
        output cmd_valid, cmd_value, cmd_mask,
        input  cmd_ready, tcam_wdata, tcam_waddr, tcam_wen, entry_valid, done
    );
    modport slave (
        input  cmd_valid, cmd_value, cmd_mask,
        output cmd_ready, tcam_wdata, tcam_waddr, tcam_wen, entry_valid, done
    );
`endif
endinterface
`default_nettype wire

// File: rtl/upb_tcam_entry_writer.sv
`default_nettype none
// ============================================================================
// Module   : upb_tcam_entry_writer
// Brief    : Shifts a (value, mask) rule into an SRL-based TCAM entry as
//            per-address match truth tables. Optional: UPB_TCAM_WRITER_INVALIDATE_EN.
// Revision : 1.0  initial release
// ============================================================================
module upb_tcam_entry_writer #(
    parameter int SRL_SIZE    = 32,
    parameter int TCAM_WIDTH  = 49,
    parameter int INPUT_WIDTH = 32
) (
    input wire                     CLK,
    input wire                     RST,
    upb_tcam_entry_writer_if.slave bus
);
    localparam int c_AW   = $clog2(SRL_SIZE);
    localparam int c_KW   = c_AW * TCAM_WIDTH;
    localparam int c_NCH  = (TCAM_WIDTH + INPUT_WIDTH - 1) / INPUT_WIDTH;
    localparam int c_CW   = (c_NCH > 1) ? $clog2(c_NCH) : 1;
    localparam int c_PADW = c_NCH * INPUT_WIDTH;

    localparam logic [c_AW-1:0] c_LAST_STEP  = c_AW'(SRL_SIZE - 1);
    localparam logic [c_CW-1:0] c_LAST_CHUNK = c_CW'(c_NCH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_nxt_state;
    logic [c_AW-1:0]        r_step;
    logic [c_AW-1:0]        w_nxt_step;
    logic [c_CW-1:0]        r_chunk;
    logic [c_CW-1:0]        w_nxt_chunk;

    logic [c_KW-1:0]        r_value;
    logic [c_KW-1:0]        r_mask;
    logic [c_KW-1:0]        w_val_src;
    logic [c_KW-1:0]        w_msk_src;
    logic                   w_inv_src;

    logic                   r_ready;
    logic                   r_wen;
    logic [INPUT_WIDTH-1:0] r_wdata;
    logic [c_CW-1:0]        r_waddr;
    logic                   r_entry_valid;
    logic                   r_done;

    logic                   w_accept;
    logic [TCAM_WIDTH-1:0]  w_fmatch;
    logic [c_PADW-1:0]      w_pad;
    logic [INPUT_WIDTH-1:0] w_lanes;

    assign w_accept = bus.cmd_valid & r_ready;

    // The first output cycle is computed in the accept cycle, before the
    // latched copy exists, so the command bus feeds the datapath directly then.
    assign w_val_src = w_accept ? bus.cmd_value : r_value;
    assign w_msk_src = w_accept ? bus.cmd_mask  : r_mask;

`ifdef UPB_TCAM_WRITER_INVALIDATE_EN
    logic r_inv;

    assign w_inv_src = w_accept ? bus.cmd_inv : r_inv;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_inv <= 1'b0;
        end else if (w_accept) begin
            r_inv <= bus.cmd_inv;
        end
    end
`else
    assign w_inv_src = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (w_accept) begin
            r_value <= bus.cmd_value;
            r_mask  <= bus.cmd_mask;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_step  <= '0;
            r_chunk <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_step  <= w_nxt_step;
            r_chunk <= w_nxt_chunk;
        end
    end

    // Steps count down because the first bit shifted ends at the deepest SRL index.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_step  = r_step;
        w_nxt_chunk = r_chunk;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_nxt_state = S_SHIFT;
                    w_nxt_step  = c_LAST_STEP;
                    w_nxt_chunk = '0;
                end
            end
            S_SHIFT: begin
                if (r_step == '0) begin
                    if (r_chunk == c_LAST_CHUNK) begin
                        w_nxt_state = S_DONE;
                    end else begin
                        w_nxt_chunk = r_chunk + c_CW'(1);
                        w_nxt_step  = c_LAST_STEP;
                    end
                end else begin
                    w_nxt_step = r_step - c_AW'(1);
                end
            end
            S_DONE: begin
                w_nxt_state = S_IDLE;
            end
            default: begin
                w_nxt_state = S_IDLE;
            end
        endcase
    end

    generate
        for (genvar f = 0; f < TCAM_WIDTH; f++) begin : g_field
            assign w_fmatch[f] =
                ((w_nxt_step ^ w_val_src[f*c_AW +: c_AW]) & w_msk_src[f*c_AW +: c_AW]) == '0;
        end
    endgenerate

    // Lanes past the last field stay zero via the padding above TCAM_WIDTH.
    always_comb begin
        w_pad                   = '0;
        w_pad[TCAM_WIDTH-1:0]   = w_fmatch & ~{TCAM_WIDTH{w_inv_src}};
    end

    assign w_lanes = w_pad[int'(w_nxt_chunk) * INPUT_WIDTH +: INPUT_WIDTH];

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ready       <= 1'b1;
            r_wen         <= 1'b0;
            r_wdata       <= '0;
            r_waddr       <= '0;
            r_entry_valid <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_ready <= (w_nxt_state == S_IDLE);
            r_wen   <= (w_nxt_state == S_SHIFT);
            r_waddr <= (w_nxt_state == S_SHIFT) ? w_nxt_chunk : '0;
            r_wdata <= (w_nxt_state == S_SHIFT) ? w_lanes : '0;
            r_done  <= (w_nxt_state == S_DONE);
            if (w_accept) begin
                r_entry_valid <= 1'b0;
            end else if (w_nxt_state == S_DONE) begin
                r_entry_valid <= ~w_inv_src;
            end
        end
    end

    assign bus.cmd_ready   = r_ready;
    assign bus.tcam_wen    = r_wen;
    assign bus.tcam_wdata  = r_wdata;
    assign bus.tcam_waddr  = r_waddr;
    assign bus.entry_valid = r_entry_valid;
    assign bus.done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_upb_tcam_entry_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_upb_tcam_entry_writer
// Brief    : Self-checking bench; a behavioural SRL entry model is loaded from
//            the writer output and looked up against ternary rule arithmetic.
// Revision : 1.0  initial release
// ============================================================================
module tb_upb_tcam_entry_writer;
    localparam int SRL_SIZE    = 32;
    localparam int TCAM_WIDTH  = 49;
    localparam int INPUT_WIDTH = 32;
    localparam int AW     = $clog2(SRL_SIZE);
    localparam int KW     = AW * TCAM_WIDTH;
    localparam int NCH    = (TCAM_WIDTH + INPUT_WIDTH - 1) / INPUT_WIDTH;
    localparam int CW     = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int NSHIFT = NCH * SRL_SIZE;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    upb_tcam_entry_writer_if #(
        .SRL_SIZE(SRL_SIZE), .TCAM_WIDTH(TCAM_WIDTH), .INPUT_WIDTH(INPUT_WIDTH)
    ) bus ();

    upb_tcam_entry_writer #(
        .SRL_SIZE(SRL_SIZE), .TCAM_WIDTH(TCAM_WIDTH), .INPUT_WIDTH(INPUT_WIDTH)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    // Downstream entry model: one SRL per field, shift-in at index 0.
    logic [SRL_SIZE-1:0] srl [TCAM_WIDTH];

    function automatic logic [KW-1:0] rand_key();
        logic [KW-1:0] r;
        for (int i = 0; i < KW; i++) r[i] = 1'($urandom_range(0, 1));
        return r;
    endfunction

    function automatic bit rule_match(input logic [KW-1:0] c, input logic [KW-1:0] v,
                                      input logic [KW-1:0] m);
        for (int f = 0; f < TCAM_WIDTH; f++)
            if (((c[f*AW +: AW] ^ v[f*AW +: AW]) & m[f*AW +: AW]) != '0) return 1'b0;
        return 1'b1;
    endfunction

    // Entry lookup as seen downstream: every SRL addressed by its field must hold 1.
    function automatic bit entry_hit(input logic [KW-1:0] c);
        if (bus.entry_valid !== 1'b1) return 1'b0;
        for (int f = 0; f < TCAM_WIDTH; f++)
            if (srl[f][c[f*AW +: AW]] !== 1'b1) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [INPUT_WIDTH-1:0] exp_lanes(input int k, input logic [KW-1:0] v,
                                                         input logic [KW-1:0] m, input bit inv);
        logic [INPUT_WIDTH-1:0] r;
        int c;
        int s;
        int f;
        r = '0;
        c = k / SRL_SIZE;
        s = SRL_SIZE - 1 - (k % SRL_SIZE);
        for (int j = 0; j < INPUT_WIDTH; j++) begin
            f = c * INPUT_WIDTH + j;
            if (f < TCAM_WIDTH && !inv)
                r[j] = ((s ^ int'(v[f*AW +: AW])) & int'(m[f*AW +: AW])) == 0;
        end
        return r;
    endfunction

    // Requests one rule load and checks the whole shift stream and DONE cycle.
    task automatic run_rule(input logic [KW-1:0] v, input logic [KW-1:0] m, input bit inv,
                            input bit perturb, input string tag);
        logic [INPUT_WIDTH-1:0] el;
        logic [CW-1:0]          ea;
        int                     f;
        n_cmp++;
        if (bus.cmd_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_ready_idle: cmd_ready=%b expected 1", tag, bus.cmd_ready);
        end
        bus.cmd_value = v;
        bus.cmd_mask  = m;
`ifdef UPB_TCAM_WRITER_INVALIDATE_EN
        bus.cmd_inv   = inv;
`endif
        bus.cmd_valid = 1'b1;
        @(posedge CLK); #1;
        bus.cmd_valid = 1'b0;
        for (int k = 0; k < NSHIFT; k++) begin
            if (perturb && k == 3) begin
                bus.cmd_value = rand_key();
                bus.cmd_mask  = rand_key();
            end
            if (perturb && k == 5) bus.cmd_valid = 1'b1;
            if (perturb && k == 9) bus.cmd_valid = 1'b0;
            el = exp_lanes(k, v, m, inv);
            ea = CW'(k / SRL_SIZE);
            n_cmp++;
            if ({bus.tcam_wen, bus.tcam_waddr, bus.tcam_wdata, bus.entry_valid, bus.done,
                 bus.cmd_ready} !== {1'b1, ea, el, 3'b000}) begin
                n_bad++;
                $display("FAIL %s_shift[%0d]: wen=%b waddr=%0d wdata=%h valid=%b done=%b ready=%b expected wen=1 waddr=%0d wdata=%h valid=0 done=0 ready=0",
                         tag, k, bus.tcam_wen, bus.tcam_waddr, bus.tcam_wdata, bus.entry_valid,
                         bus.done, bus.cmd_ready, ea, el);
            end
            if (bus.tcam_wen === 1'b1) begin
                for (int j = 0; j < INPUT_WIDTH; j++) begin
                    f = int'(bus.tcam_waddr) * INPUT_WIDTH + j;
                    if (f < TCAM_WIDTH) srl[f] = {srl[f][SRL_SIZE-2:0], bus.tcam_wdata[j]};
                end
            end
            @(posedge CLK); #1;
        end
        n_cmp++;
        if ({bus.done, bus.tcam_wen, bus.cmd_ready, bus.entry_valid} !== {3'b100, ~inv}) begin
            n_bad++;
            $display("FAIL %s_done: done=%b wen=%b ready=%b valid=%b expected done=1 wen=0 ready=0 valid=%b",
                     tag, bus.done, bus.tcam_wen, bus.cmd_ready, bus.entry_valid, ~inv);
        end
        @(posedge CLK); #1;
        n_cmp++;
        if ({bus.done, bus.cmd_ready, bus.entry_valid} !== {2'b01, ~inv}) begin
            n_bad++;
            $display("FAIL %s_after_done: done=%b ready=%b valid=%b expected done=0 ready=1 valid=%b",
                     tag, bus.done, bus.cmd_ready, bus.entry_valid, ~inv);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_value = rand_key();
        bus.cmd_mask  = rand_key();
        repeat (3) @(posedge CLK);
        #1;
        n_cmp++;
        if ({bus.cmd_ready, bus.tcam_wen, bus.entry_valid, bus.done, bus.tcam_waddr, bus.tcam_wdata}
            !== {4'b1000, {CW{1'b0}}, {INPUT_WIDTH{1'b0}}}) begin
            n_bad++;
            $display("FAIL reset_state: ready=%b wen=%b valid=%b done=%b waddr=%0d wdata=%h expected 1 0 0 0 0 0",
                     bus.cmd_ready, bus.tcam_wen, bus.entry_valid, bus.done, bus.tcam_waddr, bus.tcam_wdata);
        end
        RST = 1'b0;
        bus.cmd_valid = 1'b0;
        @(posedge CLK); #1;
        n_cmp++;
        if ({bus.cmd_ready, bus.tcam_wen, bus.done} !== 3'b100) begin
            n_bad++;
            $display("FAIL reset_wins: ready=%b wen=%b done=%b expected 1 0 0",
                     bus.cmd_ready, bus.tcam_wen, bus.done);
        end
    endtask

    task automatic test_exact_zero();
        logic [KW-1:0] c;
        bit            a;
        run_rule('0, '1, 1'b0, 1'b0, "exact0");
        c = '0;
        a = entry_hit(c);
        n_cmp++;
        if (a !== 1'b1) begin
            n_bad++;
            $display("FAIL exact0_hit: match=%b expected 1", a);
        end
        for (int i = 0; i < 20; i++) begin
            c = rand_key();
            if (c == '0) c[0] = 1'b1;
            a = entry_hit(c);
            n_cmp++;
            if (a !== 1'b0) begin
                n_bad++;
                $display("FAIL exact0_miss[%0d]: match=%b expected 0", i, a);
            end
        end
    endtask

    task automatic test_all_dont_care();
        logic [KW-1:0] c;
        bit            a;
        run_rule(rand_key(), '0, 1'b0, 1'b0, "dontcare");
        for (int i = 0; i < 100; i++) begin
            c = rand_key();
            a = entry_hit(c);
            n_cmp++;
            if (a !== 1'b1) begin
                n_bad++;
                $display("FAIL dontcare_hit[%0d]: match=%b expected 1", i, a);
            end
        end
    endtask

    task automatic test_single_field();
        logic [KW-1:0] v;
        logic [KW-1:0] m;
        logic [KW-1:0] c;
        bit            a;
        v = rand_key();
        v[4:0] = 5'h15;
        m = '0;
        m[4:0] = 5'h1F;
        run_rule(v, m, 1'b0, 1'b0, "field0");
        for (int x = 0; x < 32; x++) begin
            c = rand_key();
            c[4:0] = 5'(x);
            a = entry_hit(c);
            n_cmp++;
            if (a !== (x == 32'h15)) begin
                n_bad++;
                $display("FAIL field0_sweep[%0d]: match=%b expected %b", x, a, (x == 32'h15));
            end
        end
    endtask

    task automatic test_ignore_and_reset();
        logic [KW-1:0] v;
        logic [KW-1:0] m;
        logic [KW-1:0] c;
        bit            a;
        bit            e;
        // Stray request and changing command data during SHIFT must be ignored.
        v = rand_key();
        m = rand_key();
        run_rule(v, m, 1'b0, 1'b1, "ignore");
        c = (v & m) | (rand_key() & ~m);
        a = entry_hit(c);
        n_cmp++;
        if (a !== 1'b1) begin
            n_bad++;
            $display("FAIL ignore_latched_hit: match=%b expected 1", a);
        end
        bus.cmd_value = rand_key();
        bus.cmd_mask  = rand_key();
        bus.cmd_valid = 1'b1;
        @(posedge CLK); #1;
        bus.cmd_valid = 1'b0;
        repeat (9) begin
            @(posedge CLK); #1;
        end
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        n_cmp++;
        if ({bus.tcam_wen, bus.entry_valid, bus.cmd_ready, bus.done} !== 4'b0010) begin
            n_bad++;
            $display("FAIL midshift_reset: wen=%b valid=%b ready=%b done=%b expected 0 0 1 0",
                     bus.tcam_wen, bus.entry_valid, bus.cmd_ready, bus.done);
        end
        @(posedge CLK); #1;
        n_cmp++;
        if ({bus.tcam_wen, bus.entry_valid} !== 2'b00) begin
            n_bad++;
            $display("FAIL midshift_stays_idle: wen=%b valid=%b expected 0 0",
                     bus.tcam_wen, bus.entry_valid);
        end
        v = rand_key();
        m = rand_key();
        run_rule(v, m, 1'b0, 1'b0, "rerequest");
        for (int i = 0; i < 10; i++) begin
            c = (i % 2 == 0) ? ((v & m) | (rand_key() & ~m)) : rand_key();
            e = rule_match(c, v, m);
            a = entry_hit(c);
            n_cmp++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL rerequest_lookup[%0d]: match=%b expected %b", i, a, e);
            end
        end
    endtask

    task automatic test_random_rules();
        logic [KW-1:0] v;
        logic [KW-1:0] m;
        logic [KW-1:0] c;
        bit            a;
        bit            e;
        for (int r = 0; r < 4; r++) begin
            v = rand_key();
            m = rand_key();
            run_rule(v, m, 1'b0, 1'b0, "random");
            for (int i = 0; i < 20; i++) begin
                c = (v & m) | (rand_key() & ~m);
                if (i % 2 == 1) c = c ^ (m & rand_key());
                e = rule_match(c, v, m);
                a = entry_hit(c);
                n_cmp++;
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL random_lookup[%0d.%0d]: match=%b expected %b", r, i, a, e);
                end
            end
        end
    endtask

`ifdef UPB_TCAM_WRITER_INVALIDATE_EN
    task automatic test_invalidate();
        logic [KW-1:0] v;
        logic [KW-1:0] m;
        logic [KW-1:0] c;
        bit            a;
        v = rand_key();
        m = rand_key();
        run_rule(v, m, 1'b0, 1'b0, "preinv");
        c = (v & m) | (rand_key() & ~m);
        a = entry_hit(c);
        n_cmp++;
        if (a !== 1'b1) begin
            n_bad++;
            $display("FAIL preinv_hit: match=%b expected 1", a);
        end
        run_rule(v, m, 1'b1, 1'b0, "inv");
        for (int i = 0; i < 20; i++) begin
            c = (i == 0) ? ((v & m) | (rand_key() & ~m)) : rand_key();
            a = entry_hit(c);
            n_cmp++;
            if (a !== 1'b0) begin
                n_bad++;
                $display("FAIL inv_lookup[%0d]: match=%b expected 0", i, a);
            end
        end
        bus.cmd_inv = 1'b0;
    endtask
`endif

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_value = '0;
        bus.cmd_mask  = '0;
`ifdef UPB_TCAM_WRITER_INVALIDATE_EN
        bus.cmd_inv   = 1'b0;
`endif
        for (int f = 0; f < TCAM_WIDTH; f++) srl[f] = '0;
        test_reset();
        test_exact_zero();
        test_all_dont_care();
        test_single_field();
        test_ignore_and_reset();
        test_random_rules();
`ifdef UPB_TCAM_WRITER_INVALIDATE_EN
        test_invalidate();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
